// File: rtl/avalon_mm_mem_test_master_pkg.sv
// Shared definitions for the Avalon-MM on-chip memory test master.
// State encoding and the constant byte-enable used on every command.
package avalon_mm_mem_test_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_DRAIN,
        ST_FIN
    } state_t;

    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/avalon_mm_mem_test_master_pattern_gen.sv
// Test pattern generator: word i of a run carries seed + i (mod 2^32).
// Used once for write data and once for the expected read data.
module mem_test_pattern_gen #(
    parameter int CNT_W = 12
) (
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] index,
    output logic [31:0]      pattern
);

    assign pattern = seed + 32'(index);

endmodule

// File: rtl/avalon_mm_mem_test_master.sv
// Avalon-MM memory test master: writes seed+i over a word range, reads it
// back with up to MAX_PENDING outstanding reads and checks responses in order.
module avalon_mm_mem_test_master
    import avalon_mm_mem_test_master_pkg::*;
#(
    parameter int ADDR_W      = 13,
    parameter int CNT_W       = 12,
    parameter int MAX_PENDING = 4,
    parameter int ERR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [31:0]       seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int                PEND_W     = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PENDING);
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX    = '1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [31:0]       seed_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  rsp_idx_q;
    logic [PEND_W-1:0] pending_q;
    logic              busy_q, done_q, pass_q;
    logic [ERR_W-1:0]  err_q;
    logic [ADDR_W-1:0] ffa_q;

    logic              wr_req, rd_req, cmd_acc, rd_acc, rsp_take, mismatch;
    logic              last_idx;
    logic [31:0]       wr_pattern, exp_pattern;
    logic [ADDR_W-1:0] issue_addr, rsp_addr;

    // Byte addresses wrap modulo 2^ADDR_W; the word offset is truncated to fit.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [CNT_W-1:0]  idx);
        return base + ADDR_W'({idx, 2'b00});
    endfunction

    mem_test_pattern_gen #(.CNT_W(CNT_W)) u_issue_pat (
        .seed    (seed_q),
        .index   (idx_q),
        .pattern (wr_pattern)
    );

    mem_test_pattern_gen #(.CNT_W(CNT_W)) u_cmp_pat (
        .seed    (seed_q),
        .index   (rsp_idx_q),
        .pattern (exp_pattern)
    );

    // Commands depend only on registered state, so they stay stable while
    // waitrequest stalls them: idx_q and pending_q cannot advance meanwhile.
    assign wr_req     = (state == ST_WR);
    assign rd_req     = (state == ST_RD) && (idx_q < count_q) && (pending_q < PEND_MAX);
    assign cmd_acc    = (wr_req || rd_req) && !avm_waitrequest;
    assign rd_acc     = rd_req && !avm_waitrequest;
    assign last_idx   = (idx_q == count_q - CNT_ONE);
    assign rsp_take   = avm_readdatavalid && (pending_q != '0);
    assign mismatch   = rsp_take && (avm_readdata != exp_pattern);
    assign issue_addr = word_addr(base_q, idx_q);
    assign rsp_addr   = word_addr(base_q, rsp_idx_q);

    assign avm_write       = wr_req;
    assign avm_read        = rd_req;
    assign avm_address     = (wr_req || rd_req) ? issue_addr : '0;
    assign avm_writedata   = wr_req ? wr_pattern : '0;
    assign avm_byteenable  = (wr_req || rd_req) ? BYTEEN_ALL : 4'h0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_count     = err_q;
    assign first_fail_addr = ffa_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (word_count == '0) ? ST_FIN : ST_WR;
            ST_WR:    if (cmd_acc && last_idx) state_nxt = ST_RD;
            ST_RD:    if (rd_acc && last_idx) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pending_q == '0) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            idx_q     <= '0;
            rsp_idx_q <= '0;
            pending_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffa_q     <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_FIN);

            if (state == ST_IDLE && start) begin
                base_q    <= base_addr & ALIGN_MASK;
                count_q   <= word_count;
                seed_q    <= seed;
                idx_q     <= '0;
                rsp_idx_q <= '0;
                pass_q    <= 1'b0;
                if (word_count != '0) begin
                    busy_q <= 1'b1;
                    err_q  <= '0;
                    ffa_q  <= '0;
                end
            end

            // A zero-length run has nothing to compare and always passes.
            if (state == ST_FIN) begin
                busy_q <= 1'b0;
                pass_q <= (count_q == '0) || (err_q == '0);
            end

            if (cmd_acc)
                idx_q <= (wr_req && last_idx) ? '0 : idx_q + CNT_ONE;

            case ({rd_acc, rsp_take})
                2'b10:   pending_q <= pending_q + PEND_ONE;
                2'b01:   pending_q <= pending_q - PEND_ONE;
                default: pending_q <= pending_q;
            endcase

            if (rsp_take) begin
                rsp_idx_q <= rsp_idx_q + CNT_ONE;
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
                    if (err_q == '0) ffa_q <= rsp_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_mem_test_master.sv
// Bench for avalon_mm_mem_test_master: behavioural Avalon slave with memory,
// configurable latency/stalls/corruption, and a list-based model of each run.
module tb_avalon_mm_mem_test_master;

  localparam int MP = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [12:0] base_addr = '0;
  logic [11:0] word_count = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] error_count;
  logic [12:0] first_fail_addr;
  logic [12:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // slave configuration and observation
  bit          rand_wait = 0;
  int          lat = 1;
  bit          corrupt_en = 0;
  logic [12:0] corrupt_addr = '0;
  bit          spurious_rdv = 0;
  logic [31:0] mem [0:2047];
  typedef struct {int due; logic [31:0] data;} rsp_t;
  rsp_t        rsp_q[$];
  logic [44:0] wr_log[$];
  logic [12:0] rd_log[$];
  logic [44:0] exp_q[$];
  logic [12:0] exp_rd_q[$];
  int outstanding = 0, max_out = 0, cyc = 0;
  int stable_viol = 0, both_viol = 0, be_viol = 0, full_viol = 0, cmd_cycles = 0;
  bit prev_stall = 0;
  logic [46:0] prev_cmd = '0;

  avalon_mm_mem_test_master #(
    .ADDR_W(13), .CNT_W(12), .MAX_PENDING(MP), .ERR_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_addr(first_fail_addr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  // clock / watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // slave model: decides stalls and responses at the falling edge
  initial begin
    logic [31:0] rd;
    logic [46:0] cmd;
    foreach (mem[i]) mem[i] = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        rsp_q.delete();
        outstanding = 0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        prev_stall = 0;
      end else begin
        cmd = {avm_write, avm_read, avm_address, avm_writedata};
        if (prev_stall && cmd !== prev_cmd) stable_viol++;
        if (avm_write && avm_read) both_viol++;
        if ((avm_write || avm_read) && avm_byteenable !== 4'hF) be_viol++;
        if (avm_write || avm_read) cmd_cycles++;
        if (avm_read && outstanding >= MP) full_viol++;
        avm_readdatavalid = 1'b0;
        avm_readdata = $urandom;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = rsp_q[0].data;
          void'(rsp_q.pop_front());
          outstanding--;
        end else if (spurious_rdv) begin
          avm_readdatavalid = 1'b1;
          spurious_rdv = 0;
        end
        avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        if ((avm_write || avm_read) && !avm_waitrequest) begin
          if (avm_write) begin
            mem[avm_address[12:2]] = avm_writedata;
            wr_log.push_back({avm_address, avm_writedata});
          end else begin
            rd = mem[avm_address[12:2]];
            if (corrupt_en && avm_address == corrupt_addr) rd = rd ^ 32'h1;
            rsp_q.push_back('{cyc + lat, rd});
            rd_log.push_back(avm_address);
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
          end
        end
        prev_stall = (avm_write || avm_read) && avm_waitrequest;
        prev_cmd = cmd;
      end
    end
  end

  // reference model: word i lives at aligned base + 4*i (mod 8192), holds seed + i
  function automatic logic [12:0] model_addr(input logic [12:0] b, input int i);
    return 13'(((int'(b) & ~3) + 4 * i) % 8192);
  endfunction

  function automatic void build_exp(input logic [12:0] b, input int n, input logic [31:0] s);
    exp_q.delete();
    exp_rd_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({model_addr(b, i), s + 32'(i)});
      exp_rd_q.push_back(model_addr(b, i));
    end
  endfunction

  function automatic int log_diffs();
    int d = 0;
    if (wr_log.size() != exp_q.size() || rd_log.size() != exp_rd_q.size()) return 9999;
    foreach (exp_q[i]) if (wr_log[i] !== exp_q[i]) d++;
    foreach (exp_rd_q[i]) if (rd_log[i] !== exp_rd_q[i]) d++;
    return d;
  endfunction

  // driver tasks
  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    max_out = 0; stable_viol = 0; both_viol = 0; be_viol = 0; full_viol = 0; cmd_cycles = 0;
  endtask

  task automatic run_once(input logic [12:0] b, input logic [11:0] n, input logic [31:0] s,
                          output int done_at, output bit pulse_ok, output bit busy_seen);
    int budget;
    budget = 40 * int'(n) + 100;
    done_at = -1; pulse_ok = 0; busy_seen = 0;
    @(negedge clk);
    base_addr = b; word_count = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    for (int c = 1; c <= budget; c++) begin
      if (done) begin done_at = c; break; end
      @(negedge clk);
    end
    if (done_at >= 0) begin
      @(negedge clk);
      pulse_ok = !done;
    end
  endtask

  // tests
  task automatic test_reset();
    tests_run++;
    if ({busy, done, pass} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass});
    end
    tests_run++;
    if ({error_count, first_fail_addr} !== 29'h0) begin
      tests_failed++; $display("FAIL reset_results: err %0h ffa %0h want 0", error_count, first_fail_addr);
    end
    tests_run++;
    if ({avm_write, avm_read, avm_address, avm_writedata, avm_byteenable} !== 51'h0) begin
      tests_failed++; $display("FAIL reset_bus: wr %b rd %b addr %0h be %0h want 0", avm_write, avm_read, avm_address, avm_byteenable);
    end
  endtask

  task automatic test_basic();
    int done_at; bit pulse_ok, busy_seen; int d;
    rand_wait = 0; lat = 1; corrupt_en = 0;
    clear_logs();
    build_exp(13'h0, 4, 32'h1000);
    run_once(13'h0, 12'd4, 32'h1000, done_at, pulse_ok, busy_seen);
    tests_run++;
    if (done_at < 0) begin tests_failed++; $display("FAIL basic_done: timeout, want done pulse"); end
    tests_run++;
    if (!pulse_ok || !busy_seen) begin
      tests_failed++; $display("FAIL basic_pulse_busy: pulse_ok %0d busy %0d want 1 1", pulse_ok, busy_seen);
    end
    d = log_diffs();
    tests_run++;
    if (d != 0) begin tests_failed++; $display("FAIL basic_bus_trace: %0d diffs want 0 (wr %0d rd %0d)", d, wr_log.size(), rd_log.size()); end
    tests_run++;
    if (pass !== 1'b1 || error_count !== 16'd0) begin
      tests_failed++; $display("FAIL basic_result: pass %b err %0d want 1 0", pass, error_count);
    end
  endtask

  task automatic test_waitrequest();
    int done_at; bit pulse_ok, busy_seen; int bad;
    rand_wait = 1; lat = 1; corrupt_en = 0;
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
    clear_logs();
    build_exp(13'h0, 4, 32'h1000);
    run_once(13'h0, 12'd4, 32'h1000, done_at, pulse_ok, busy_seen);
    tests_run++;
    if (stable_viol != 0 || both_viol != 0 || be_viol != 0) begin
      tests_failed++; $display("FAIL wait_protocol: stable %0d both %0d be %0d want 0", stable_viol, both_viol, be_viol);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[i] !== 32'h1000 + 32'(i)) bad++;
    tests_run++;
    if (bad != 0 || log_diffs() != 0) begin tests_failed++; $display("FAIL wait_memory: %0d bad words, trace diffs %0d want 0", bad, log_diffs()); end
    tests_run++;
    if (done_at < 0 || pass !== 1'b1) begin tests_failed++; $display("FAIL wait_pass: done_at %0d pass %b want 1", done_at, pass); end
    rand_wait = 0;
  endtask

  task automatic test_corrupt();
    int done_at; bit pulse_ok, busy_seen;
    rand_wait = 0; lat = 1; corrupt_en = 1; corrupt_addr = 13'h8;
    clear_logs();
    run_once(13'h0, 12'd4, 32'h1000, done_at, pulse_ok, busy_seen);
    tests_run++;
    if (done_at < 0 || error_count !== 16'd1) begin tests_failed++; $display("FAIL corrupt_count: done_at %0d err %0d want 1", done_at, error_count); end
    tests_run++;
    if (first_fail_addr !== 13'h8) begin tests_failed++; $display("FAIL corrupt_addr: got %0h want 8", first_fail_addr); end
    tests_run++;
    if (pass !== 1'b0) begin tests_failed++; $display("FAIL corrupt_pass: got %b want 0", pass); end
    corrupt_en = 0;
  endtask

  task automatic test_zero_count();
    int done_at; bit pulse_ok, busy_seen;
    clear_logs();
    run_once(13'h40, 12'd0, 32'hDEAD, done_at, pulse_ok, busy_seen);
    tests_run++;
    if (done_at != 2) begin tests_failed++; $display("FAIL zero_done_at: got %0d want 2", done_at); end
    tests_run++;
    if (pass !== 1'b1 || !pulse_ok) begin tests_failed++; $display("FAIL zero_pass: pass %b pulse_ok %0d want 1 1", pass, pulse_ok); end
    tests_run++;
    if (cmd_cycles != 0) begin tests_failed++; $display("FAIL zero_no_cmd: %0d command cycles want 0", cmd_cycles); end
  endtask

  task automatic test_start_while_busy();
    int done_at; bit pulse_ok, busy_seen;
    logic [31:0] s;
    s = $urandom;
    rand_wait = 0; lat = 2;
    clear_logs();
    build_exp(13'h100, 8, s);
    fork
      run_once(13'h100, 12'd8, s, done_at, pulse_ok, busy_seen);
      begin
        repeat (4) @(negedge clk);
        base_addr = 13'h400; word_count = 12'd3; seed = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    tests_run++;
    if (wr_log.size() != 8 || log_diffs() != 0) begin
      tests_failed++; $display("FAIL busy_start_writes: %0d writes, %0d diffs want 8 0", wr_log.size(), log_diffs());
    end
    tests_run++;
    if (done_at < 0 || pass !== 1'b1) begin tests_failed++; $display("FAIL busy_start_pass: done_at %0d pass %b want 1", done_at, pass); end
  endtask

  task automatic test_pending_limit();
    int done_at; bit pulse_ok, busy_seen;
    logic [31:0] s;
    s = $urandom;
    rand_wait = 0; lat = 3;
    clear_logs();
    build_exp(13'h200, 16, s);
    run_once(13'h200, 12'd16, s, done_at, pulse_ok, busy_seen);
    tests_run++;
    if (max_out != MP) begin tests_failed++; $display("FAIL pend_max: got %0d want %0d", max_out, MP); end
    tests_run++;
    if (full_viol != 0) begin tests_failed++; $display("FAIL pend_read_at_full: %0d cycles want 0", full_viol); end
    tests_run++;
    if (done_at < 0 || pass !== 1'b1 || error_count !== 16'd0 || log_diffs() != 0) begin
      tests_failed++; $display("FAIL pend_result: done_at %0d pass %b err %0d diffs %0d want ok", done_at, pass, error_count, log_diffs());
    end
    lat = 1;
  endtask

  task automatic test_reset_midrun();
    int done_at; bit pulse_ok, busy_seen; bit reached;
    logic [31:0] s;
    s = $urandom;
    rand_wait = 0; lat = 1;
    clear_logs();
    @(negedge clk);
    base_addr = 13'h0; word_count = 12'd16; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 0;
    for (int c = 0; c < 100; c++) begin
      if (wr_log.size() >= 5) begin reached = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!reached) begin tests_failed++; $display("FAIL midrun_reach: %0d writes want 5", wr_log.size()); end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, pass, error_count, first_fail_addr, avm_write, avm_read, avm_address, avm_writedata, avm_byteenable} !== 83'h0) begin
      tests_failed++; $display("FAIL midrun_async_reset: busy %b wr %b addr %0h want 0", busy, avm_write, avm_address);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    spurious_rdv = 1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (error_count !== 16'd0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrun_stray_rsp: err %0d busy %b want 0 0", error_count, busy); end
    clear_logs();
    build_exp(13'h20, 2, 32'h55);
    run_once(13'h20, 12'd2, 32'h55, done_at, pulse_ok, busy_seen);
    tests_run++;
    if (done_at < 0 || pass !== 1'b1 || log_diffs() != 0) begin
      tests_failed++; $display("FAIL midrun_rerun: done_at %0d pass %b diffs %0d want pass", done_at, pass, log_diffs());
    end
  endtask

  task automatic test_random();
    int done_at; bit pulse_ok, busy_seen;
    logic [12:0] b; int n; logic [31:0] s; int k;
    logic [15:0] exp_err; logic [12:0] exp_ffa;
    for (int it = 0; it < 8; it++) begin
      b = (it == 0) ? 13'h1FF2 : 13'($urandom_range(0, 8191));
      n = $urandom_range(1, 40);
      s = $urandom;
      rand_wait = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 5);
      corrupt_en = 1'($urandom_range(0, 1));
      k = $urandom_range(0, n - 1);
      corrupt_addr = model_addr(b, k);
      exp_err = corrupt_en ? 16'd1 : 16'd0;
      exp_ffa = corrupt_en ? model_addr(b, k) : 13'h0;
      clear_logs();
      build_exp(b, n, s);
      run_once(b, 12'(n), s, done_at, pulse_ok, busy_seen);
      tests_run++;
      if (done_at < 0 || log_diffs() != 0 || stable_viol != 0 || max_out > MP) begin
        tests_failed++;
        $display("FAIL rand_bus[%0d]: done_at %0d diffs %0d stable %0d max_out %0d", it, done_at, log_diffs(), stable_viol, max_out);
      end
      tests_run++;
      if (error_count !== exp_err || first_fail_addr !== exp_ffa || pass !== (exp_err == 0)) begin
        tests_failed++;
        $display("FAIL rand_result[%0d]: err %0d ffa %0h pass %b want %0d %0h %b", it, error_count, first_fail_addr, pass, exp_err, exp_ffa, exp_err == 0);
      end
    end
    corrupt_en = 0; rand_wait = 0; lat = 1;
  endtask

  // sequence and final report
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_basic();
    test_waitrequest();
    test_corrupt();
    test_zero_count();
    test_start_while_busy();
    test_pending_limit();
    test_reset_midrun();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
